// File: rtl/dcache_pkg.sv
// dcache_pkg: shared FSM state type and default cache geometry
//   DEF_SETS / DEF_WORDS : default line count and words per line
//   IDX_W / OFF_W / TAG_W: address field widths for the default geometry
package dcache_pkg;
  localparam int DEF_SETS = 16;
  localparam int DEF_WORDS = 4;
  localparam int IDX_W = $clog2(DEF_SETS);
  localparam int OFF_W = $clog2(DEF_WORDS);
  localparam int TAG_W = 32 - IDX_W - OFF_W - 2;
  typedef enum logic [1:0] {IDLE, REFILL, WRITE} state_t;
endpackage

// File: rtl/dcache_if.sv
// dcache_if: memory-stage request bus and backing-memory bus of the data cache
//   cpu side : req_valid_M, req_write_M, addr_M, wdata_M, wstrb_M -> rdata_M, stall
//   mem side : mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb -> mem_ack, mem_rdata
//   slave modport is the cache view, master modport the pipeline/memory view
interface dcache_if;
  logic req_valid_M, req_write_M, stall;
  logic [31:0] addr_M, wdata_M, rdata_M;
  logic [3:0] wstrb_M;
  logic mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0] mem_wstrb;
  modport slave(
    input req_valid_M, req_write_M, addr_M, wdata_M, wstrb_M, mem_ack, mem_rdata,
    output rdata_M, stall, mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
  );
  modport master(
    output req_valid_M, req_write_M, addr_M, wdata_M, wstrb_M, mem_ack, mem_rdata,
    input rdata_M, stall, mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
  );
endinterface

// File: rtl/dcache_array.sv
// dcache_array: tag, valid and data storage for a direct-mapped cache
//   idx           : line selected for read, write and fill
//   rword / wword : word offset for the async read and the sync write
//   tag, valid, rdata : async read of the selected line
//   we, wstrb, wdata  : byte-strobed sync data write
//   fill, fill_tag    : set tag and valid of the selected line
//   rst               : async clear of all valid bits only
module dcache_array
  import dcache_pkg::*;
#(
  parameter int SETS = DEF_SETS,
  parameter int WORDS = DEF_WORDS,
  parameter int TW = TAG_W
) (
  input  logic clk,
  input  logic rst,
  input  logic [$clog2(SETS)-1:0] idx,
  input  logic [$clog2(WORDS)-1:0] rword,
  input  logic [$clog2(WORDS)-1:0] wword,
  output logic [TW-1:0] tag,
  output logic valid,
  output logic [31:0] rdata,
  input  logic we,
  input  logic [3:0] wstrb,
  input  logic [31:0] wdata,
  input  logic fill,
  input  logic [TW-1:0] fill_tag
);
  logic [31:0] data [SETS*WORDS];
  logic [TW-1:0] tags [SETS];
  logic [SETS-1:0] valid_q;
  assign tag = tags[idx];
  assign valid = valid_q[idx];
  assign rdata = data[{idx, rword}];
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (we && wstrb[i]) data[{idx, wword}][8*i +: 8] <= wdata[8*i +: 8];
    if (fill) tags[idx] <= fill_tag;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) valid_q <= '0;
    else if (fill) valid_q[idx] <= 1'b1;
endmodule

// File: rtl/data_cache.sv
// data_cache: direct-mapped, write-through, no-write-allocate data cache
//   clk, rst : clock and async active-high reset
//   bus      : dcache_if.slave (memory-stage request and backing-memory bus)
//   hit_count, miss_count : access statistics, present only with DCACHE_STATS_EN
module data_cache
  import dcache_pkg::*;
#(
  parameter int SETS = DEF_SETS,
  parameter int WORDS_PER_LINE = DEF_WORDS
) (
  input logic clk,
  input logic rst,
  dcache_if.slave bus
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);
  localparam int IW = $clog2(SETS);
  localparam int OW = $clog2(WORDS_PER_LINE);
  localparam int TW = 32 - IW - OW - 2;
  state_t state, state_n;
  logic [OW-1:0] cnt;
  logic [31:2] addr_q, a;
  logic [31:0] wdata_q, arr_rdata, arr_wdata;
  logic [3:0] wstrb_q, arr_wstrb;
  logic [TW-1:0] arr_tag;
  logic [OW-1:0] wword;
  logic arr_valid, hit, we, fill;
  // the pipeline holds the request during stall, but the latched copy keeps
  // the memory bus stable whatever happens upstream
  assign a = state == IDLE ? bus.addr_M[31:2] : addr_q;
  assign hit = arr_valid && arr_tag == a[31 -: TW];
  dcache_array #(.SETS(SETS), .WORDS(WORDS_PER_LINE), .TW(TW)) u_array (
    .clk(clk),
    .rst(rst),
    .idx(a[OW+2 +: IW]),
    .rword(bus.addr_M[2 +: OW]),
    .wword(wword),
    .tag(arr_tag),
    .valid(arr_valid),
    .rdata(arr_rdata),
    .we(we),
    .wstrb(arr_wstrb),
    .wdata(arr_wdata),
    .fill(fill),
    .fill_tag(addr_q[31 -: TW])
  );
  assign bus.rdata_M = state == IDLE && bus.req_valid_M && !bus.req_write_M && hit ? arr_rdata : 32'd0;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_wstrb = wstrb_q;
  always_comb begin
    state_n = state;
    bus.stall = 1'b0;
    bus.mem_req = 1'b0;
    bus.mem_we = 1'b0;
    bus.mem_addr = {addr_q, 2'b00};
    we = 1'b0;
    fill = 1'b0;
    arr_wstrb = 4'hf;
    arr_wdata = bus.mem_rdata;
    wword = cnt;
    case (state)
      IDLE: begin
        bus.stall = bus.req_valid_M && (bus.req_write_M || !hit);
        state_n = !bus.req_valid_M ? IDLE : bus.req_write_M ? WRITE : hit ? IDLE : REFILL;
      end
      REFILL: begin
        bus.stall = 1'b1;
        bus.mem_req = 1'b1;
        bus.mem_addr = {addr_q[31:OW+2], cnt, 2'b00};
        we = bus.mem_ack;
        fill = bus.mem_ack && cnt == OW'(WORDS_PER_LINE - 1);
        state_n = fill ? IDLE : REFILL;
      end
      WRITE: begin
        // the store retires in the ack cycle, so stall drops with it
        bus.stall = !bus.mem_ack;
        bus.mem_req = 1'b1;
        bus.mem_we = 1'b1;
        we = bus.mem_ack && hit;
        arr_wstrb = wstrb_q;
        arr_wdata = wdata_q;
        wword = addr_q[2 +: OW];
        state_n = bus.mem_ack ? IDLE : WRITE;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
    end else begin
      state <= state_n;
      if (state == REFILL && bus.mem_ack) cnt <= cnt + 1'b1;
    end
  always_ff @(posedge clk)
    if (state == IDLE && bus.req_valid_M) begin
      addr_q <= bus.addr_M[31:2];
      wdata_q <= bus.wdata_M;
      wstrb_q <= bus.wstrb_M;
    end
`ifdef DCACHE_STATS_EN
  logic replay;
  // the load held through a refill re-presents itself once; do not count it twice
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      hit_count <= '0;
      miss_count <= '0;
      replay <= 1'b0;
    end else begin
      replay <= fill ? 1'b1 : state == IDLE ? 1'b0 : replay;
      if (state == IDLE && bus.req_valid_M && !replay) begin
        hit_count <= hit_count + 32'(hit);
        miss_count <= miss_count + 32'(!hit);
      end
    end
`endif
endmodule

// File: tb/tb_data_cache.sv
// tb_data_cache: randomized self-checking bench for data_cache against a line/memory model
module tb_data_cache;
  localparam int WPL = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  dcache_if bus();
  data_cache dut(.clk(clk), .rst(rst), .bus(bus));
  int n_chk = 0, n_pass = 0, n_reads = 0, n_writes = 0, lat = 0;
  logic [31:0] rd_q[$];
  logic [31:0] bmem[logic [31:0]];
  logic [31:0] rmem[logic [31:0]];
  logic [31:0] last_waddr, last_wdata, last_rdata;
  logic [3:0] last_wstrb;
  logic m_valid[16];
  logic [23:0] m_tag[16];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction
  function automatic logic [31:0] bget(input logic [31:0] a);
    return bmem.exists(a) ? bmem[a] : init_word(a);
  endfunction
  function automatic logic [31:0] rget(input logic [31:0] a);
    return rmem.exists(a) ? rmem[a] : init_word(a);
  endfunction

  initial begin
    logic [31:0] w;
    bus.mem_ack = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      bus.mem_ack = 1'b0;
      if (bus.mem_req) begin
        if (lat > 0) lat--;
        else begin
          bus.mem_ack = 1'b1;
          lat = $urandom_range(0, 2);
          if (bus.mem_we) begin
            w = bget(bus.mem_addr);
            for (int i = 0; i < 4; i++) if (bus.mem_wstrb[i]) w[8*i +: 8] = bus.mem_wdata[8*i +: 8];
            bmem[bus.mem_addr] = w;
            last_waddr = bus.mem_addr;
            last_wdata = bus.mem_wdata;
            last_wstrb = bus.mem_wstrb;
            n_writes++;
          end else begin
            bus.mem_rdata = bget(bus.mem_addr);
            rd_q.push_back(bus.mem_addr);
            n_reads++;
          end
        end
      end
    end
  end

  task automatic access(input bit wr, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws);
    int r0, w0, cyc;
    bit hit;
    logic [3:0] ix;
    logic [23:0] tg;
    logic [31:0] wa, base, m;
    wa = {a[31:2], 2'b00};
    base = {a[31:4], 4'h0};
    ix = a[7:4];
    tg = a[31:8];
    hit = m_valid[ix] && m_tag[ix] == tg;
    r0 = n_reads;
    w0 = n_writes;
    rd_q.delete();
    bus.req_valid_M = 1'b1;
    bus.req_write_M = wr;
    bus.addr_M = a;
    bus.wdata_M = wd;
    bus.wstrb_M = ws;
    #1;
    chk("stall_first", 32'(bus.stall), 32'(wr || !hit));
    cyc = 0;
    while (bus.stall && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    chk("stall_timeout", 32'(cyc < 200), 32'd1);
    if (wr) begin
      chk("store_nwrites", 32'(n_writes - w0), 32'd1);
      chk("store_addr", last_waddr, wa);
      chk("store_data", last_wdata, wd);
      chk("store_strb", 32'(last_wstrb), 32'(ws));
      chk("store_nreads", 32'(n_reads - r0), 32'd0);
      m = rget(wa);
      for (int i = 0; i < 4; i++) if (ws[i]) m[8*i +: 8] = wd[8*i +: 8];
      rmem[wa] = m;
    end else begin
      last_rdata = bus.rdata_M;
      chk("load_rdata", bus.rdata_M, rget(wa));
      chk("load_nwrites", 32'(n_writes - w0), 32'd0);
      chk("load_nreads", 32'(n_reads - r0), hit ? 32'd0 : 32'(WPL));
      if (!hit) begin
        chk("miss_stall_len", 32'(cyc >= 5), 32'd1);
        for (int i = 0; i < WPL && i < rd_q.size(); i++) chk("refill_addr", rd_q[i], base + 32'(4 * i));
        m_valid[ix] = 1'b1;
        m_tag[ix] = tg;
      end
    end
    @(posedge clk);
    #1;
    bus.req_valid_M = 1'b0;
  endtask

  initial begin
    int cyc, r0, k, l;
    logic [31:0] a, wd;
    logic [3:0] ws;
    bus.req_valid_M = 1'b0;
    bus.req_write_M = 1'b0;
    bus.addr_M = '0;
    bus.wdata_M = '0;
    bus.wstrb_M = '0;
    foreach (m_valid[i]) m_valid[i] = 1'b0;
    for (int i = 0; i < WPL; i++) begin
      bmem[32'h100 + 32'(4 * i)] = 32'hA0 + 32'(i);
      rmem[32'h100 + 32'(4 * i)] = 32'hA0 + 32'(i);
    end
    @(negedge clk);
    @(negedge clk);
    chk("reset_stall", 32'(bus.stall), 32'd0);
    chk("reset_mem_req", 32'(bus.mem_req), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    access(0, 32'h100, 0, 0);
    chk("req034_rdata", last_rdata, 32'hA0);
    access(0, 32'h104, 0, 0);
    chk("req035_rdata", last_rdata, 32'hA1);
    access(1, 32'h105, 32'h0000FF00, 4'b0010);
    access(0, 32'h104, 0, 0);
    chk("req036_merge", last_rdata, 32'h0000FFA1);
    access(1, 32'h2000, 32'h12345678, 4'hf);
    access(0, 32'h2000, 0, 0);
    access(0, 32'h100, 0, 0);
    access(0, 32'h500, 0, 0);
    access(0, 32'h100, 0, 0);
    #1;
    chk("idle_stall", 32'(bus.stall), 32'd0);
    chk("idle_rdata", bus.rdata_M, 32'd0);
    r0 = n_reads;
    bus.req_valid_M = 1'b1;
    bus.req_write_M = 1'b0;
    bus.addr_M = 32'h500;
    cyc = 0;
    while (n_reads - r0 < 2 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    chk("rst_wait", 32'(cyc < 100), 32'd1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    bus.req_valid_M = 1'b0;
    #1;
    chk("rst_mid_mem_req", 32'(bus.mem_req), 32'd0);
    chk("rst_mid_stall", 32'(bus.stall), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    foreach (m_valid[i]) m_valid[i] = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_mem_req", 32'(bus.mem_req), 32'd0);
    access(0, 32'h100, 0, 0);
    chk("req039_rdata", last_rdata, 32'hA0);
    for (int n = 0; n < 300; n++) begin
      l = $urandom_range(0, 3);
      a = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 15)) << 4) | (32'($urandom_range(0, 3)) << 2);
      if ($urandom_range(0, 2) == 0) begin
        k = $urandom_range(0, 2);
        ws = k == 0 ? 4'(1 << l) : k == 1 ? 4'(3 << (l & 2)) : 4'hf;
        a = a | 32'(k == 0 ? l : k == 1 ? (l & 2) : 0);
        wd = $urandom;
        access(1, a, wd, ws);
      end else access(0, a | 32'(l), 0, 0);
      if ($urandom_range(0, 7) == 0) begin
        @(negedge clk);
        chk("gap_stall", 32'(bus.stall), 32'd0);
        chk("gap_rdata", bus.rdata_M, 32'd0);
        @(posedge clk);
        #1;
      end
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule
